// File: rtl/fpu_unpack_pkg.sv
// Shared types and field geometry for the FPU significand unpacker.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package fpu_unpack_pkg;

  typedef enum logic [1:0] {
    FMT_SP = 2'b00,
    FMT_DP = 2'b01,
    FMT_HP = 2'b10
  } fmt_e;

  localparam int SIG_W  = 53;
  localparam int LZ_W   = 6;
  localparam int FRAC_W = SIG_W - 1;

  // Field positions inside the 64-bit operand word (formats are top-aligned).
  localparam int DP_EXP_W    = 11;
  localparam int DP_EXP_LSB  = 52;
  localparam int DP_FRAC_W   = 52;
  localparam int DP_FRAC_LSB = 0;

  localparam int SP_EXP_W    = 8;
  localparam int SP_EXP_LSB  = 55;
  localparam int SP_FRAC_W   = 23;
  localparam int SP_FRAC_LSB = 32;

  localparam int HP_EXP_W    = 5;
  localparam int HP_EXP_LSB  = 58;
  localparam int HP_FRAC_W   = 10;
  localparam int HP_FRAC_LSB = 48;

  // Stage-1 register contents (tag travels separately since its width is a parameter).
  typedef struct packed {
    logic [SIG_W-1:0] h;
    logic [LZ_W-1:0]  lz;
    logic             fz;
    logic             denorm;
    logic             normal;
  } S1_t;

endpackage

// File: rtl/sig_lzc.sv
// Leading-zero counter over a W-bit significand; all-zero input reports W.
// Latency: combinational.
// Backpressure: none, pure function of the input.
module sig_lzc #(
  parameter int W   = 53,
  parameter int LZW = 6
) (
  input  logic [W-1:0]   d,
  output logic [LZW-1:0] lz
);

  // Scan from the MSB; the first set bit fixes the count, none leaves the clamp value.
  always_comb begin
    logic found;
    found = 1'b0;
    lz    = LZW'(W);
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && d[i]) begin
        lz    = LZW'(W - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sig_unpack_pipe.sv
// Significand unpacker: extract, classify, count leading zeros, optionally normalise.
// Latency: 2 cycles from accept to out_valid; one operand per cycle.
// Backpressure: valid/ready; stalled stages hold, in_ready drops only when both stages are full and blocked.
module sig_unpack_pipe
  import fpu_unpack_pkg::*;
#(
  parameter int TAGW = 4,
  parameter int SW   = 53,
  parameter int LZW  = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [63:0]     fp,
  input  logic [1:0]      fmt,
  input  logic            normal,
  input  logic [TAGW-1:0] tag_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SW-1:0]   h,
  output logic [SW-1:0]   f,
  output logic [LZW-1:0]  lz,
  output logic            fz,
  output logic            denorm,
  output logic [TAGW-1:0] tag_out
);

  logic              e_z;
  logic [FRAC_W-1:0] frac;
  logic [SIG_W-1:0]  h_in;
  logic [LZW-1:0]    lz_in;
  S1_t               s1_d;

  logic              s1_valid;
  S1_t               s1;
  logic [TAGW-1:0]   s1_tag;

  logic              s2_valid;
  logic [SW-1:0]     s2_h;
  logic [SW-1:0]     s2_f;
  logic [LZW-1:0]    s2_lz;
  logic              s2_fz;
  logic              s2_denorm;
  logic [TAGW-1:0]   s2_tag;

  logic              s2_adv;
  logic              s1_adv;

  // Per-format exponent-zero detect and left-aligned fraction placement; reserved format decodes as double.
  always_comb begin
    e_z  = 1'b0;
    frac = '0;
    case (fmt_e'(fmt))
      FMT_SP: begin
        e_z  = ~|fp[SP_EXP_LSB +: SP_EXP_W];
        frac = {fp[SP_FRAC_LSB +: SP_FRAC_W], {(FRAC_W - SP_FRAC_W){1'b0}}};
      end
      FMT_HP: begin
        e_z  = ~|fp[HP_EXP_LSB +: HP_EXP_W];
        frac = {fp[HP_FRAC_LSB +: HP_FRAC_W], {(FRAC_W - HP_FRAC_W){1'b0}}};
      end
      default: begin
        e_z  = ~|fp[DP_EXP_LSB +: DP_EXP_W];
        frac = fp[DP_FRAC_LSB +: DP_FRAC_W];
      end
    endcase
  end

  assign h_in = {~e_z, frac};

  sig_lzc #(
    .W   (SW),
    .LZW (LZW)
  ) u_lzc (
    .d  (h_in),
    .lz (lz_in)
  );

  // Assemble the stage-1 payload; infinities and NaNs pass through with the hidden bit set.
  always_comb begin
    s1_d        = '0;
    s1_d.h      = h_in;
    s1_d.lz     = lz_in;
    s1_d.fz     = ~|h_in;
    s1_d.denorm = e_z & (|frac);
    s1_d.normal = normal;
  end

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Stage 1: capture the classified operand; flush wins over any transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
      s1_tag   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1     <= s1_d;
        s1_tag <= tag_in;
      end
    end
  end

  // Stage 2: normalising shift (zero operand shifts out to zero) and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_h      <= '0;
      s2_f      <= '0;
      s2_lz     <= '0;
      s2_fz     <= 1'b0;
      s2_denorm <= 1'b0;
      s2_tag    <= '0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_h      <= s1.h;
        s2_f      <= s1.normal ? (s1.h << s1.lz) : s1.h;
        s2_lz     <= s1.lz;
        s2_fz     <= s1.fz;
        s2_denorm <= s1.denorm;
        s2_tag    <= s1_tag;
      end
    end
  end

  assign out_valid = s2_valid;
  assign h         = s2_h;
  assign f         = s2_f;
  assign lz        = s2_lz;
  assign fz        = s2_fz;
  assign denorm    = s2_denorm;
  assign tag_out   = s2_tag;

endmodule

// File: tb/tb_sig_unpack_pipe.sv
// Scoreboard bench for sig_unpack_pipe with a format-rule reference model.
// Latency: checks the 2-cycle accept-to-output timing on an empty pipe.
// Backpressure: exercises stalls, flush, async reset and random out_ready.
module tb_sig_unpack_pipe;

  localparam int TAGW = 4;
  localparam int SW   = 53;
  localparam int LZW  = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [63:0]     fp;
  logic [1:0]      fmt;
  logic            normal;
  logic [TAGW-1:0] tag_in;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   h;
  logic [SW-1:0]   f;
  logic [LZW-1:0]  lz;
  logic            fz;
  logic            denorm;
  logic [TAGW-1:0] tag_out;

  typedef struct packed {
    logic [52:0]     h;
    logic [52:0]     f;
    logic [5:0]      lz;
    logic            fz;
    logic            denorm;
    logic [TAGW-1:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   popped   = 0;
  bit   rand_ready = 1'b0;

  sig_unpack_pipe #(
    .TAGW (TAGW),
    .SW   (SW),
    .LZW  (LZW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp        (fp),
    .fmt       (fmt),
    .normal    (normal),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .h         (h),
    .f         (f),
    .lz        (lz),
    .fz        (fz),
    .denorm    (denorm),
    .tag_out   (tag_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: fields located by width arithmetic; leading zeros from the bit length of h.
  function automatic exp_t model(input logic [63:0] p, input logic [1:0] m,
                                 input logic n, input logic [TAGW-1:0] t);
    exp_t        r;
    int          ew;
    int          fw;
    int          sh;
    logic [63:0] e;
    logic [63:0] fr;
    logic [63:0] hv;
    case (m)
      2'b00:   begin ew = 8;  fw = 23; end
      2'b10:   begin ew = 5;  fw = 10; end
      default: begin ew = 11; fw = 52; end
    endcase
    e  = (p >> (63 - ew)) & ((64'd1 << ew) - 64'd1);
    fr = (p >> (63 - ew - fw)) & ((64'd1 << fw) - 64'd1);
    hv = ((e == 64'd0) ? 64'd0 : (64'd1 << 52)) | (fr << (52 - fw));
    sh = 53 - $clog2(hv + 64'd1);
    r.h      = hv[52:0];
    r.lz     = sh[5:0];
    r.f      = n ? 53'(hv << sh) : hv[52:0];
    r.fz     = (hv == 64'd0);
    r.denorm = (e == 64'd0) && (fr != 64'd0);
    r.tag    = t;
    return r;
  endfunction

  // Monitor: every output transfer is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: tag %h emitted with nothing outstanding", tag_out);
      end else begin
        mon_e = sb.pop_front();
        chk("out_h", 64'(h), 64'(mon_e.h));
        chk("out_f", 64'(f), 64'(mon_e.f));
        chk("out_lz", 64'(lz), 64'(mon_e.lz));
        chk("out_fz", 64'(fz), 64'(mon_e.fz));
        chk("out_denorm", 64'(denorm), 64'(mon_e.denorm));
        chk("out_tag", 64'(tag_out), 64'(mon_e.tag));
        popped++;
      end
    end
  end

  // Random downstream readiness when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Present one operand and hold it until accepted; returns 1ns after the accepting edge.
  task automatic drive_op(input logic [63:0] p, input logic [1:0] m,
                          input logic n, input logic [TAGW-1:0] t);
    bit done;
    done     = 1'b0;
    fp       = p;
    fmt      = m;
    normal   = n;
    tag_in   = t;
    in_valid = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(p, m, n, t));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: tag %h never accepted, in_ready %b", t, in_ready);
    end
  endtask

  task automatic wait_drain();
    bit empty;
    empty = 1'b0;
    for (int c = 0; c < 300 && !empty; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) empty = 1'b1;
    end
    @(posedge clk);
    #1;
    if (!empty) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d results outstanding, out_valid %b", sb.size(), out_valid);
    end
  endtask

  function automatic logic [63:0] rand_fp();
    logic [63:0] p;
    p = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: p = 64'd0;
      1: p[62:52] = 11'd0;
      2: begin
        p[62:52] = 11'd0;
        p[51:0]  = p[51:0] >> $urandom_range(0, 52);
      end
      3: p[62:0] = 63'd1 << $urandom_range(0, 62);
      default: ;
    endcase
    return p;
  endfunction

  exp_t bp_first;
  int   p0;

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    fp        = '0;
    fmt       = 2'b00;
    normal    = 1'b0;
    tag_in    = '0;
    out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_h", 64'(h), 64'd0);
    chk("rst_f", 64'(f), 64'd0);
    chk("rst_lz", 64'(lz), 64'd0);
    chk("rst_fz", 64'(fz), 64'd0);
    chk("rst_denorm", 64'(denorm), 64'd0);
    chk("rst_tag", 64'(tag_out), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Latency on an empty pipe with double 1.0
    out_ready = 1'b1;
    drive_op(64'h3FF0_0000_0000_0000, 2'b01, 1'b1, 4'd1);
    @(negedge clk);
    chk("latency_early_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("latency_out_valid", 64'(out_valid), 64'd1);
    chk("dp_one_h", 64'(h), 64'h0010_0000_0000_0000);
    chk("dp_one_lz", 64'(lz), 64'd0);
    @(posedge clk);
    #1;

    // Directed operands from the format rules
    drive_op(64'h0000_0000_0000_0001, 2'b01, 1'b1, 4'd2);
    drive_op(64'h0000_0000_0000_0001, 2'b01, 1'b0, 4'd3);
    drive_op({32'h3FC0_0000, 32'h0}, 2'b00, 1'b1, 4'd4);
    drive_op({16'h3C00, 48'h0}, 2'b10, 1'b1, 4'd5);
    drive_op(64'h0, 2'b01, 1'b1, 4'd6);
    drive_op(64'h3FF0_0000_0000_0000, 2'b11, 1'b1, 4'd7);
    drive_op(64'h7FF8_0000_0000_0001, 2'b01, 1'b0, 4'd8);
    wait_drain();

    // Backpressure: two accepted, third blocked, then simultaneous pop and push
    out_ready = 1'b0;
    p0 = popped;
    bp_first = model(64'h0008_0000_0000_0000, 2'b01, 1'b1, 4'd1);
    drive_op(64'h0008_0000_0000_0000, 2'b01, 1'b1, 4'd1);
    drive_op({32'h0000_0001, 32'h0}, 2'b00, 1'b1, 4'd2);
    fp       = {16'h0001, 48'h0};
    fmt      = 2'b10;
    normal   = 1'b1;
    tag_in   = 4'd3;
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_hold_tag", 64'(tag_out), 64'(bp_first.tag));
      chk("bp_hold_f", 64'(f), 64'(bp_first.f));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_rise", 64'(in_ready), 64'd1);
    @(negedge clk);
    if (in_ready) sb.push_back(model(fp, fmt, normal, tag_in));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_drain();
    chk("bp_delivered", 64'(popped - p0), 64'd3);

    // Flush with both stages full; the concurrent input is dropped
    out_ready = 1'b0;
    drive_op(64'h4000_0000_0000_0000, 2'b01, 1'b1, 4'd9);
    drive_op(64'h0000_0000_0000_00FF, 2'b01, 1'b1, 4'd10);
    p0       = popped;
    fp       = 64'h3FF0_0000_0000_0000;
    fmt      = 2'b01;
    tag_in   = 4'd11;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    sb.delete();
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("flush_no_output", 64'(popped - p0), 64'd0);
    @(posedge clk);
    #1;
    drive_op(64'hBFF8_0000_0000_0000, 2'b01, 1'b1, 4'd12);
    wait_drain();

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    drive_op(64'h0000_0000_0001_0000, 2'b01, 1'b1, 4'd13);
    drive_op(64'h3FF0_0000_0000_0000, 2'b01, 1'b1, 4'd14);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_h", 64'(h), 64'd0);
    chk("arst_f", 64'(f), 64'd0);
    chk("arst_tag", 64'(tag_out), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomised traffic with random downstream stalls
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      drive_op(rand_fp(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               TAGW'($urandom_range(0, 15)));
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    wait_drain();
    chk("final_outstanding", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sig_unpack_pipe.md
# sig_unpack_pipe

Two-stage pipelined significand unpacker for the FPU front end, the successor to the combinational significand unpacker. It extracts the significand of a half-, single- or double-precision operand, classifies it (zero / denormal), counts leading zeros, and optionally normalises it. A valid/ready handshake lets it sit between the operand-fetch buffer and the exponent/normalise-adjust stage.

## Interface
- `TAGW`, default 4: width of the opaque tag carried alongside each operand.
- `SW`, default 53: significand width including the hidden bit; fixed by the double format.
- `LZW`, default 6: leading-zero count width.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous pipeline kill.
- `in_valid`  in  1  operand present.
- `in_ready`  out  1  operand accepted when high together with `in_valid`.
- `fp`  in  64  packed operand. Double uses `fp[63:0]`; single uses `fp[63:32]`; half uses `fp[63:48]`.
- `fmt`  in  2  format select: 00 single, 01 double, 10 half, 11 reserved (treated as double).
- `normal`  in  1  normalise enable.
- `tag_in`  in  TAGW  tag.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  downstream accept.
- `h`  out  SW  raw significand, hidden bit in bit 52, left-aligned.
- `f`  out  SW  `normal ? h << lz : h`.
- `lz`  out  LZW  leading zeros of `h`, 0..53.
- `fz`  out  1  `h == 0`.
- `denorm`  out  1  exponent field zero and fraction non-zero.
- `tag_out`  out  TAGW  tag.

## Operation
- **Exponent-zero detect.** Computed internally per format: double `fp[62:52]`, single `fp[62:55]`, half `fp[62:58]`.
- **Fraction placement.** The fraction is left-aligned into `h[51:0]` and zero-filled below:
  - double `fp[51:0]`;
  - single `{fp[54:32], 29'b0}`;
  - half `{fp[57:48], 42'b0}`.
  - `h[52] = ~e_z`.
- **Stage 1 (S1).** Register `h`, `fz`, `denorm`, `normal`, `tag`, and `lz` from sub-module `sig_lzc`.
- **Stage 2 (S2).** Register `f` (shift of S1 `h` by S1 `lz`, or a pass-through when `normal` is 0) and copy the other fields.
- **Zero operand.** `lz` = 53, `f` = 0, `fz` = 1, `denorm` = 0.
- **Infinity/NaN.** No special handling; the fraction is passed as-is with the hidden bit set.
- **Handshake.**
  - S2 advances when `!s2_valid || out_ready`.
  - S1 advances when `!s1_valid || s2_advance`.
  - `in_ready = !s1_valid || s2_advance` (combinational, no dependence on `in_valid`).
  - Data in a stalled stage holds stable; `out_valid` never drops without `out_ready`.
- **Flush.**
  - Clears `s1_valid` and `s2_valid` at the next edge.
  - An input offered in the same cycle is dropped.
  - Flush has priority over a transfer.
- **Reset.**
  - All valids 0 and all data outputs 0, so `in_ready` = 1.
  - Asynchronous assertion mid-stream discards in-flight operands immediately.

## Timing
- Latency is 2 cycles from the accepting edge to `out_valid`, with no stalls. Throughput is 1 operand/cycle.
- Outputs are registered (S2 flops). `in_ready` is the only combinational output.
- Full pipe with `out_ready` low: `in_ready` = 0 the same cycle. It rises in the cycle `out_ready` rises.
- Simultaneous output pop and input push with the pipe full: all three operands shift, with no bubble.
- Ordering is strictly FIFO. No reordering and no duplication.

## Structure
- **Package `fpu_unpack_pkg`.** Holds:
  - `fmt_e` enum (`FMT_SP`, `FMT_DP`, `FMT_HP`);
  - `SIG_W` = 53, `LZ_W` = 6;
  - per-format exponent and fraction widths/offsets;
  - `S1_t` packed struct for the stage register.
- **Sub-module `sig_lzc`.** 53-bit leading-zero counter with a zero→53 clamp, shared with the exponent-adjust block.
- The normalise shifter is inline.

## Test plan
- **Double 1.0.** `fp`=0x3FF0000000000000, `fmt`=01, `normal`=1 → 2 cycles later `h`=0x10000000000000, `lz`=0, `f`=`h`, `fz`=0, `denorm`=0.
- **Minimum double denormal.** `fp`=0x0000000000000001:
  - `normal`=1 → `h`=1, `lz`=52, `f`=0x10000000000000, `denorm`=1;
  - `normal`=0 → `f`=1.
- **Single and half.**
  - Single 1.5, `fp[63:32]`=0x3FC00000, `fmt`=00 → `h`=0x18000000000000, `lz`=0.
  - Half 1.0, `fp[63:48]`=0x3C00, `fmt`=10 → `h`=0x10000000000000.
- **Zero.** `fp`=0, `fmt`=01 → `fz`=1, `lz`=53, `f`=0, `denorm`=0.
- **Backpressure.** Push tags 1,2,3 back-to-back with `out_ready` low:
  - `in_ready` falls after tags 1 and 2 are accepted;
  - outputs hold tag 1 stable;
  - raising `out_ready` delivers 1,2,3 in order, with no loss or duplicates.
- **Flush and reset.**
  - `flush` with both stages full → `out_valid`=0 next cycle, `in_ready`=1.
  - `rst_n` low mid-stream → `out_valid`=0 asynchronously and all outputs zero.
